seq_stream_arbiter: RTL and testbench
=====================================

SEQ_STREAM_ARBITER -- requirements
Module: seq_stream_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, bits per serial transaction (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1 each  requester N presents a word.
REQ-005 SHALL have ports: req0_data, req1_data  input  WIDTH each  word to serialise, LSB first.
REQ-006 SHALL have ports: req0_ready, req1_ready  output  1 each  word accepted when valid and ready are both high at a clock edge.
REQ-007 SHALL have ports: req0_done, req1_done  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have ports: req0_result, req1_result  output  WIDTH each  captured detector output word.
REQ-009 SHALL have port: dut_x  output  1  serial bit driven to the detector input.
REQ-010 SHALL have port: dut_z  input  1  detector output, combinationally valid in the same cycle as dut_x.
REQ-011 SHALL have port: dut_clr  output  1  active-high clear for the detector flip-flops.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, SHIFT, DONE.
- IDLE -> CLEAR on an accept.
- CLEAR -> SHIFT after exactly one cycle.
- SHIFT -> DONE after exactly WIDTH cycles.
- DONE -> IDLE after exactly one cycle.
REQ-014 SHALL assert reqN_ready only in IDLE, and only for the granted requester.
- reqN_ready is combinational from state, valids and the grant pointer.
- Both ready outputs are 0 outside IDLE.
REQ-015 SHALL arbitrate round-robin.
- If only one requester is valid, it is granted.
- If both are valid, the requester not granted last is granted.
- last_grant is 1 after reset, so req0 wins the first tie.
REQ-016 SHALL, on accept, latch reqN_data into a shift register and record the owner; last_grant updates at the same edge.
REQ-017 SHALL drive dut_clr=1 during the CLEAR cycle and whenever rst=1; dut_clr is 0 otherwise.
REQ-018 SHALL drive dut_x as follows.
- In SHIFT cycle i (0..WIDTH-1), dut_x = data[i].
- dut_x = 0 in all other states.
REQ-019 SHALL sample dut_z at the end of SHIFT cycle i into result bit i.
REQ-020 SHALL, in DONE, pulse the owner's reqN_done for one cycle and load the owner's reqN_result with the captured word.
- The non-owner's result is unchanged.
- Each result holds until that requester's next DONE.
REQ-021 SHALL give fixed latency: with accept at edge T, dut_clr is high in cycle T+1, bits occupy cycles T+2..T+WIDTH+1, and done is high in cycle T+WIDTH+2.
REQ-022 SHALL permit the next accept at the earliest in the IDLE cycle T+WIDTH+3.
REQ-023 SHALL let a valid be raised or dropped while not ready with no effect; data is sampled only at the accept edge.
REQ-024 SHALL use a bit counter of ceil(log2(WIDTH)) bits that never wraps past WIDTH-1.

Reset
REQ-025 SHALL, while rst=1, asynchronously force the following:
- state=IDLE, last_grant=1;
- shift register, counter and both results = 0;
- all ready/done outputs, dut_x and busy = 0;
- dut_clr=1.
REQ-026 SHALL abandon any in-flight transaction on reset mid-operation, with no done pulse for it.

Verification (bench loops dut_z = dut_x unless stated)
REQ-027 SHALL cover reset: rst=1 -> busy=0, readies=0, dones=0, dut_x=0, dut_clr=1, results=0.
REQ-028 SHALL cover a single request: req0 0xA5 (WIDTH=8).
- Expected: ready high in cycle 0, dut_clr high in cycle 1.
- dut_x = 1,0,1,0,0,1,0,1 in cycles 2..9.
- req0_done in cycle 10, req0_result=0xA5.
REQ-029 SHALL cover a tie: req0 0x3C and req1 0xC3 both valid from reset.
- Expected: req0 accepted at cycle 0 with done at 10.
- req1 accepted at cycle 11, with req1_ready 0 in cycles 1..10.
- req1 done at cycle 21, req1_result=0xC3.
REQ-030 SHALL cover round-robin under a held valid: both requesters continuously valid over 4 transactions -> grant order 0,1,0,1.
REQ-031 SHALL cover a stuck detector: dut_z tied 0, req1 0xFF -> req1_result=0x00; req0_result unchanged.
REQ-032 SHALL cover reset mid-operation: rst pulsed during SHIFT bit 4 of a req0 transaction.
- Expected: busy=0 immediately, no req0_done.
- After release, a tie is granted to req0 and completes with the correct result.

Source files
------------

// File: rtl/seq_stream_arbiter.sv
// Two-requester round-robin front end that serialises a word LSB first into an
// external sequence detector and returns the detector's output word to the owner.
module seq_stream_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  output logic             req0_done,
  output logic [WIDTH-1:0] req0_result,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             req1_done,
  output logic [WIDTH-1:0] req1_result,
  output logic             dut_x,
  input  logic             dut_z,
  output logic             dut_clr,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic             owner;
  logic             grant_c;
  logic             accept_c;
  logic             last_bit_c;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_final_c;
  logic [CW-1:0]    cnt;

  assign last_bit_c  = (cnt == CW'(WIDTH - 1));
  assign cap_final_c = {dut_z, cap[WIDTH-1:1]};

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) grant_c = ~last_grant;
    else if (req1_valid)          grant_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational handshake and detector drive.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_c   = 1'b0;
    dut_x      = 1'b0;
    dut_clr    = rst;
    case (state)
      S_IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = ~grant_c;
          req1_ready = grant_c;
          accept_c   = 1'b1;
          state_nxt  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        dut_clr   = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        dut_x = shreg[0];
        if (last_bit_c) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift out / shift in, deliver to the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      shreg       <= '0;
      cap         <= '0;
      cnt         <= '0;
      req0_result <= '0;
      req1_result <= '0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy      <= (state_nxt != S_IDLE);
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            shreg      <= grant_c ? req1_data : req0_data;
            owner      <= grant_c;
            last_grant <= grant_c;
            cnt        <= '0;
          end
        end
        S_SHIFT: begin
          shreg <= shreg >> 1;
          cap   <= cap_final_c;
          if (!last_bit_c) begin
            cnt <= cnt + CW'(1);
          end else if (owner) begin
            req1_result <= cap_final_c;
            req1_done   <= 1'b1;
          end else begin
            req0_result <= cap_final_c;
            req0_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_arbiter.sv
// Directed bench for seq_stream_arbiter with the detector modelled as a wire loop.
module tb_seq_stream_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic         req0_ready;
  logic         req0_done;
  logic [W-1:0] req0_result;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data = '0;
  logic         req1_ready;
  logic         req1_done;
  logic [W-1:0] req1_result;
  logic         dut_x;
  logic         dut_z;
  logic         dut_clr;
  logic         busy;
  logic         stuck = 1'b0;

  int vectors = 0;
  int errors  = 0;

  assign dut_z = stuck ? 1'b0 : dut_x;

  always #5 clk = ~clk;

  seq_stream_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_result(req0_result),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_result(req1_result),
    .dut_x(dut_x), .dut_z(dut_z), .dut_clr(dut_clr), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    vectors++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++; if (req0_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready0: got %b exp 0", req0_ready); end
    vectors++; if (req1_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready1: got %b exp 0", req1_ready); end
    vectors++; if (req0_done !== 1'b0)   begin errors++; $display("FAIL reset_done0: got %b exp 0", req0_done); end
    vectors++; if (req1_done !== 1'b0)   begin errors++; $display("FAIL reset_done1: got %b exp 0", req1_done); end
    vectors++; if (dut_x !== 1'b0)       begin errors++; $display("FAIL reset_x: got %b exp 0", dut_x); end
    vectors++; if (dut_clr !== 1'b1)     begin errors++; $display("FAIL reset_clr: got %b exp 1", dut_clr); end
    vectors++; if (req0_result !== 8'h00) begin errors++; $display("FAIL reset_result0: got %h exp 00", req0_result); end
    vectors++; if (req1_result !== 8'h00) begin errors++; $display("FAIL reset_result1: got %h exp 00", req1_result); end
    step(); step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++; if (dut_clr !== 1'b0) begin errors++; $display("FAIL release_clr: got %b exp 0", dut_clr); end
  endtask

  task automatic test_single;
    logic [W-1:0] d;
    d = 8'hA5;
    req0_data = d; req0_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b exp 1", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b exp 0", req1_ready); end
    step();
    req0_valid = 1'b0; req0_data = 8'h00;
    for (int c = 1; c <= 11; c++) begin
      #1;
      vectors++; if (dut_clr !== (c == 1)) begin errors++; $display("FAIL single_clr c%0d: got %b exp %b", c, dut_clr, (c == 1)); end
      vectors++; if (dut_x !== ((c >= 2 && c <= 9) ? d[c-2] : 1'b0)) begin errors++; $display("FAIL single_x c%0d: got %b", c, dut_x); end
      vectors++; if (req0_done !== (c == 10)) begin errors++; $display("FAIL single_done c%0d: got %b exp %b", c, req0_done, (c == 10)); end
      vectors++; if (busy !== (c <= 10)) begin errors++; $display("FAIL single_busy c%0d: got %b exp %b", c, busy, (c <= 10)); end
      if (c == 10) begin
        vectors++; if (req0_result !== 8'hA5) begin errors++; $display("FAIL single_result: got %h exp a5", req0_result); end
      end
      step();
    end
  endtask

  task automatic test_tie;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    d0 = 8'h3C; d1 = 8'hC3;
    do_reset();
    req0_data = d0; req1_data = d1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL tie_ready0: got %b exp 1", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie_ready1: got %b exp 0", req1_ready); end
    step();
    req0_valid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      #1;
      if (c <= 10) begin
        vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie_ready1_hold c%0d: got %b exp 0", c, req1_ready); end
      end
      if (c >= 2 && c <= 9) begin
        vectors++; if (dut_x !== d0[c-2]) begin errors++; $display("FAIL tie_x0 c%0d: got %b exp %b", c, dut_x, d0[c-2]); end
      end
      if (c == 10) begin
        vectors++; if (req0_done !== 1'b1) begin errors++; $display("FAIL tie_done0: got %b exp 1", req0_done); end
        vectors++; if (req1_done !== 1'b0) begin errors++; $display("FAIL tie_done1_early: got %b exp 0", req1_done); end
        vectors++; if (req0_result !== 8'h3C) begin errors++; $display("FAIL tie_result0: got %h exp 3c", req0_result); end
      end
      if (c == 11) begin
        vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL tie_ready1_grant: got %b exp 1", req1_ready); end
      end
      if (c == 12) begin
        vectors++; if (dut_clr !== 1'b1) begin errors++; $display("FAIL tie_clr1: got %b exp 1", dut_clr); end
      end
      if (c >= 13 && c <= 20) begin
        vectors++; if (dut_x !== d1[c-13]) begin errors++; $display("FAIL tie_x1 c%0d: got %b exp %b", c, dut_x, d1[c-13]); end
      end
      if (c == 21) begin
        vectors++; if (req1_done !== 1'b1) begin errors++; $display("FAIL tie_done1: got %b exp 1", req1_done); end
        vectors++; if (req1_result !== 8'hC3) begin errors++; $display("FAIL tie_result1: got %h exp c3", req1_result); end
        vectors++; if (req0_result !== 8'h3C) begin errors++; $display("FAIL tie_result0_hold: got %h exp 3c", req0_result); end
      end
      step();
      if (c == 11) req1_valid = 1'b0;
    end
  endtask

  task automatic test_round_robin;
    logic         own;
    logic [W-1:0] exp_d;
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      own = (k % 2) == 1;
      req0_data = 8'h40 | W'(k);
      req1_data = 8'hB0 | W'(k);
      exp_d = own ? (8'hB0 | W'(k)) : (8'h40 | W'(k));
      #1;
      vectors++; if (req0_ready !== !own) begin errors++; $display("FAIL rr_ready0 t%0d: got %b exp %b", k, req0_ready, !own); end
      vectors++; if (req1_ready !== own)  begin errors++; $display("FAIL rr_ready1 t%0d: got %b exp %b", k, req1_ready, own); end
      step();
      for (int c = 1; c <= 10; c++) begin
        #1;
        if (c == 10) begin
          vectors++; if (req0_done !== !own) begin errors++; $display("FAIL rr_done0 t%0d: got %b exp %b", k, req0_done, !own); end
          vectors++; if (req1_done !== own)  begin errors++; $display("FAIL rr_done1 t%0d: got %b exp %b", k, req1_done, own); end
          vectors++; if ((own ? req1_result : req0_result) !== exp_d) begin
            errors++; $display("FAIL rr_result t%0d: got %h exp %h", k, own ? req1_result : req0_result, exp_d);
          end
        end
        step();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_stuck;
    stuck = 1'b1;
    req1_data = 8'hFF; req1_valid = 1'b1;
    #1;
    vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stuck_ready1: got %b exp 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c >= 2 && c <= 9) begin
        vectors++; if (dut_x !== 1'b1) begin errors++; $display("FAIL stuck_x c%0d: got %b exp 1", c, dut_x); end
      end
      if (c == 10) begin
        vectors++; if (req1_done !== 1'b1) begin errors++; $display("FAIL stuck_done1: got %b exp 1", req1_done); end
        vectors++; if (req1_result !== 8'h00) begin errors++; $display("FAIL stuck_result1: got %h exp 00", req1_result); end
        vectors++; if (req0_result !== 8'h42) begin errors++; $display("FAIL stuck_result0_hold: got %h exp 42", req0_result); end
      end
      step();
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid;
    req0_data = 8'h5A; req0_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0: got %b exp 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1;
    vectors++; if (busy !== 1'b1)  begin errors++; $display("FAIL mid_busy_pre: got %b exp 1", busy); end
    vectors++; if (dut_x !== 1'b1) begin errors++; $display("FAIL mid_x_bit4: got %b exp 1", dut_x); end
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0)    begin errors++; $display("FAIL mid_busy_rst: got %b exp 0", busy); end
    vectors++; if (dut_x !== 1'b0)   begin errors++; $display("FAIL mid_x_rst: got %b exp 0", dut_x); end
    vectors++; if (dut_clr !== 1'b1) begin errors++; $display("FAIL mid_clr_rst: got %b exp 1", dut_clr); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++; if (req0_done !== 1'b0) begin errors++; $display("FAIL mid_no_done c%0d: got %b exp 0", c, req0_done); end
      vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_idle c%0d: got %b exp 0", c, busy); end
      step();
    end
    req0_data = 8'h96; req1_data = 8'h69; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_tie_ready0: got %b exp 1", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL mid_tie_ready1: got %b exp 0", req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c == 10) begin
        vectors++; if (req0_done !== 1'b1) begin errors++; $display("FAIL mid_done0: got %b exp 1", req0_done); end
        vectors++; if (req1_done !== 1'b0) begin errors++; $display("FAIL mid_done1: got %b exp 0", req1_done); end
        vectors++; if (req0_result !== 8'h96) begin errors++; $display("FAIL mid_result0: got %h exp 96", req0_result); end
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_stuck();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
